// File: rtl/aes256_key_expand_if.sv
// Handshake bundle between the AES-256 key expander, its key requester and the round-key consumer.
// Round-key store ports exist only when AES_KEXP_STORE_EN is defined.
interface aes256_key_expand_if;
  logic         start;
  logic [255:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;
`ifdef AES_KEXP_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         keys_ready;
`endif

  modport master (
    output start, key, rk_ready,
`ifdef AES_KEXP_STORE_EN
    output rd_idx,
    input  rd_key, keys_ready,
`endif
    input  busy, rk_valid, rk, rk_idx, rk_last
  );

  modport slave (
    input  start, key, rk_ready,
`ifdef AES_KEXP_STORE_EN
    input  rd_idx,
    output rd_key, keys_ready,
`endif
    output busy, rk_valid, rk, rk_idx, rk_last
  );
endinterface

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: emits rk0..rk14 one per valid/ready handshake from an 8-word window.
// Optional AES_KEXP_STORE_EN adds a 15x128 round-key store with a registered read port.
module aes256_key_expand #(
  parameter int RK_COUNT = 15
) (
  input logic                clk,
  input logic                rst,
  aes256_key_expand_if.slave bus
);
  localparam logic [3:0] LAST_IDX = 4'(RK_COUNT - 1);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0x00 sits in the top byte of the table, so the bit offset is (255 - b) * 8.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   win_q [8];
  logic [31:0]   win_d [8];
  logic [127:0]  rk_q, rk_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [31:0]   t, nw0, nw1, nw2, nw3;
  logic          hs;

  assign hs = (state_q == EMIT) && bus.rk_ready;

  // An odd current index means the next round index is even and takes the RotWord/Rcon path.
  assign t   = idx_q[0] ? (sub_word({win_q[7][23:0], win_q[7][31:24]}) ^ {rcon_q, 24'h0})
                        : sub_word(win_q[7]);
  assign nw0 = win_q[0] ^ t;
  assign nw1 = win_q[1] ^ nw0;
  assign nw2 = win_q[2] ^ nw1;
  assign nw3 = win_q[3] ^ nw2;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 8; i++) win_d[i] = bus.key[255 - 32*i -: 32];
          rk_d    = bus.key[255:128];
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else if (idx_q == 4'd0) begin
            rk_d  = {win_q[4], win_q[5], win_q[6], win_q[7]};
            idx_d = 4'd1;
          end else begin
            for (int i = 0; i < 4; i++) win_d[i] = win_q[i + 4];
            win_d[4] = nw0;
            win_d[5] = nw1;
            win_d[6] = nw2;
            win_d[7] = nw3;
            rk_d     = {nw0, nw1, nw2, nw3};
            idx_d    = idx_q + 4'd1;
            if (idx_q[0]) rcon_d = {rcon_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int i = 0; i < 8; i++) win_q[i] <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign bus.busy     = (state_q == EMIT);
  assign bus.rk_valid = (state_q == EMIT);
  assign bus.rk_last  = (state_q == EMIT) && (idx_q == LAST_IDX);
  assign bus.rk       = rk_q;
  assign bus.rk_idx   = idx_q;

`ifdef AES_KEXP_STORE_EN
  logic [127:0] store_q [RK_COUNT];
  logic [127:0] rd_key_q;
  logic         keys_ready_q;

  always_ff @(posedge clk) begin
    if (hs) store_q[idx_q] <= rk_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_key_q     <= '0;
      keys_ready_q <= 1'b0;
    end else begin
      rd_key_q <= (bus.rd_idx <= LAST_IDX) ? store_q[bus.rd_idx] : '0;
      if ((state_q == IDLE) && bus.start) keys_ready_q <= 1'b0;
      else if (hs && (idx_q == LAST_IDX)) keys_ready_q <= 1'b1;
    end
  end

  assign bus.rd_key     = rd_key_q;
  assign bus.keys_ready = keys_ready_q;
`endif
endmodule

// File: tb/tb_aes256_key_expand.sv
// Randomized bench for aes256_key_expand against a FIPS-197 key-schedule model built from GF(2^8) arithmetic.
module tb_aes256_key_expand;
  typedef logic [127:0] rk_arr_t [15];

  localparam logic [255:0] K =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk;
  logic rst;
  aes256_key_expand_if bus();

  aes256_key_expand dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks = 0;
  int      failures = 0;
  bit      rand_ready = 0;
  logic [7:0] sb [256];

  bit      mdl_active = 0;
  bit      mdl_kr = 0;
  int      mdl_idx = 0;
  int      hs_count = 0;
  int      streams_done = 0;
  rk_arr_t mdl_rk;
  rk_arr_t last_rk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] s, input int k);
    return 8'((s << k) | (s >> (8 - k)));
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic rk_arr_t expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    rk_arr_t     r;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // Single compare process: checks every cycle against the stream model.
  always @(negedge clk) begin
    if (!rst) begin
      mdl_active = 0;
      mdl_kr = 0;
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_valid", 128'(bus.rk_valid), 128'd0);
      chk("rst_last", 128'(bus.rk_last), 128'd0);
      chk("rst_rk", bus.rk, 128'd0);
      chk("rst_idx", 128'(bus.rk_idx), 128'd0);
`ifdef AES_KEXP_STORE_EN
      chk("rst_keys_ready", 128'(bus.keys_ready), 128'd0);
`endif
    end else begin
`ifdef AES_KEXP_STORE_EN
      chk("keys_ready", 128'(bus.keys_ready), 128'(mdl_kr));
`endif
      if (mdl_active) begin
        chk("valid", 128'(bus.rk_valid), 128'd1);
        chk("busy", 128'(bus.busy), 128'd1);
        chk("rk", bus.rk, mdl_rk[mdl_idx]);
        chk("rk_idx", 128'(bus.rk_idx), 128'(mdl_idx));
        chk("rk_last", 128'(bus.rk_last), 128'(mdl_idx == 14));
        if (bus.rk_ready) begin
          hs_count++;
          if (mdl_idx == 14) begin
            mdl_active = 0;
            last_rk = mdl_rk;
            mdl_kr = 1;
            streams_done++;
          end else begin
            mdl_idx++;
          end
        end
      end else begin
        chk("idle_valid", 128'(bus.rk_valid), 128'd0);
        chk("idle_busy", 128'(bus.busy), 128'd0);
        chk("idle_last", 128'(bus.rk_last), 128'd0);
        if (bus.start) begin
          mdl_rk = expand(bus.key);
          mdl_idx = 0;
          mdl_active = 1;
          mdl_kr = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.rk_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (mdl_active && n < 500) begin
      tick();
      n++;
    end
    chk("stream_timeout", 128'(n >= 500), 128'd0);
  endtask

  task automatic pulse_start(input logic [255:0] k);
    bus.key = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n = 0;
    while (!(bus.rk_valid && bus.rk_idx == target) && n < 500) begin
      tick();
      n++;
    end
    chk("wait_idx_timeout", 128'(n >= 500), 128'd0);
  endtask

  initial begin
    rk_arr_t pin;
    int      hs0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    rst = 1'b0;
    bus.start = 1'b0;
    bus.key = '0;
    bus.rk_ready = 1'b0;
`ifdef AES_KEXP_STORE_EN
    bus.rd_idx = 4'd0;
`endif
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Literal pins on the model itself.
    chk("pin_sbox00", 128'(sb[8'h00]), 128'h63);
    chk("pin_sbox53", 128'(sb[8'h53]), 128'hed);
    pin = expand(K);
    chk("pin_k_rk0", pin[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("pin_k_rk1", pin[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("pin_k_rk2", pin[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("pin_k_rk14", pin[14], 128'hfe4890d1e6188d0b046df344706c631e);
    pin = expand('0);
    chk("pin_z_rk1", pin[1], 128'd0);
    chk("pin_z_rk2", pin[2], 128'h62636363626363636263636362636363);

    // Full-rate stream.
    bus.rk_ready = 1'b1;
    hs0 = hs_count;
    pulse_start(K);
    wait_done();
    chk("hs_full_rate", 128'(hs_count - hs0), 128'd15);
    repeat (2) tick();

    // Random backpressure.
    rand_ready = 1;
    hs0 = hs_count;
    pulse_start(K);
    wait_done();
    chk("hs_backpressure", 128'(hs_count - hs0), 128'd15);

    // start mid-stream with a different key must be ignored.
    pulse_start(K);
    wait_idx(4'd5);
    pulse_start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    wait_done();
    repeat (2) tick();

    // Reset mid-stream, then a fresh stream.
    pulse_start(K);
    wait_idx(4'd7);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    pulse_start(K);
    wait_done();

    // All-zero key.
    pulse_start('0);
    wait_done();

    // start coinciding with the final handshake is dropped.
    rand_ready = 0;
    bus.rk_ready = 1'b1;
    pulse_start(K);
    wait_idx(4'd14);
    pulse_start(~K);
    repeat (3) tick();
    chk("restart_dropped", 128'(mdl_active), 128'd0);

    // Random keys under random backpressure.
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      pulse_start({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

`ifdef AES_KEXP_STORE_EN
    rand_ready = 0;
    bus.rk_ready = 1'b1;
    pulse_start(K);
    wait_done();
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      tick();
      chk("rd_key", bus.rd_key, (i < 15) ? last_rk[i] : 128'd0);
    end
    bus.rd_idx = 4'd14;
    tick();
    chk("rd_key14_lit", bus.rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
`endif

    rand_ready = 0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aes256_key_expand.md
Name: aes256_key_expand

Overview:
- Generates the 15 AES-256 round keys (rk0..rk14, 128 bits each) from a 256-bit cipher key, per the FIPS-197 key schedule.
- Sits directly upstream of the AES256 round datapath and feeds it the round keys in order, one per valid/ready handshake.
- Iterative: one round key is produced per cycle from an internal 8-word window, with backpressure.

Parameters:
- RK_COUNT, 15, number of round keys emitted; fixed for AES-256, any other value is illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to expand `key`; sampled only in IDLE.
- key  input  256  cipher key, key[255:224] = w0 … key[31:0] = w7; sampled when start is accepted.
- busy  output  1  high from start acceptance until the rk14 handshake completes.
- rk_valid  output  1  rk/rk_idx hold a valid round key.
- rk_ready  input  1  consumer accepts rk this cycle when rk_valid is also high.
- rk  output  128  round key, rk[127:96] = first word of the round.
- rk_idx  output  4  round index 0..14 of rk.
- rk_last  output  1  high together with rk_valid when rk_idx = 14.

Behaviour:
- Reset (rst low, async): state = IDLE; busy, rk_valid and rk_last = 0; rk = 0; rk_idx = 0; window and Rcon cleared.
- States: IDLE, EMIT.
- IDLE, start = 1:
  - Load window W[0..7] = key words.
  - Set rk = key[255:128], rk_idx = 0, Rcon = 0x01.
  - Go to EMIT; rk_valid = 1 and busy = 1 from the next cycle (latency 1).
- EMIT, rk_valid & rk_ready (handshake):
  - If rk_idx = 14: go to IDLE; rk_valid, busy and rk_last drop next cycle.
  - Else if rk_idx = 0: rk = key[127:0] (window words 4..7), rk_idx = 1.
  - Else compute 4 new words and present them as rk with rk_idx + 1.
- New-word computation (next rk_idx = n ≥ 2):
  - Let p = most recent window word.
  - n even: t = SubWord(RotWord(p)) ^ {Rcon, 24'h0}; Rcon then doubles (0x01, 0x02, … 0x40; no GF reduction is needed).
  - n odd: t = SubWord(p).
  - Chain the four words: w'0 = W[old0] ^ t, w'1 = W[old1] ^ w'0, w'2 = W[old2] ^ w'1, w'3 = W[old3] ^ w'2.
  - Shift the window by 4 words; the new words go at the end.
- SubWord: four combinational forward S-box lookups (FIPS-197 table); RotWord = rotate left by 8.
- Backpressure: while rk_valid & !rk_ready, rk, rk_idx and rk_last hold stable; the window does not advance.
- start in EMIT: ignored; no restart and no corruption of the stream.
- start in the same cycle as the final handshake: ignored; the block returns to IDLE and the requester must reissue.
- rst asserted mid-stream: immediate return to reset state; a partial stream is never resumed.
- rk_ready while rk_valid = 0: no effect.

Optional Feature:
- Macro: AES_KEXP_STORE_EN.
- Defined:
  - Adds a 15×128 register file written on every handshake at address rk_idx.
  - Adds ports rd_idx (input, 4 bits), rd_key (output, 128 bits) and keys_ready (output, 1 bit).
  - rd_key = store[rd_idx], registered, 1-cycle latency.
  - rd_idx > 14 returns 0.
  - keys_ready resets to 0, clears on start acceptance, and sets the cycle after the rk14 handshake.
  - The decryption datapath uses this to read keys in reverse order.
- Undefined: no storage and no extra ports; streaming only.

Test Plan:
- Test key: K = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 (FIPS-197 A.3).
- K with rk_ready held high, start at cycle T -> rk0 = 603deb1015ca71be2b73aef0857d7781 at T+1; rk1 = 1f352c073b6108d72d9810a30914dff4; rk2 = 9ba354118e6925afa51a8b5f2067fcde; rk14 = fe4890d1e6188d0b046df344706c631e with rk_last = 1 at T+15; busy = 0 at T+16.
- K with rk_ready toggled pseudo-randomly (50%) -> identical 15-key sequence; rk and rk_idx stable on every stalled cycle; exactly 15 handshakes.
- start pulsed again at rk_idx = 5 with a different key -> ignored; the sequence still matches K.
- rst driven low while rk_idx = 7, then start with K -> all outputs 0 during reset; the new stream begins at rk0 = 603deb10…7781 with Rcon restarted (rk2 = 9ba35411…fcde).
- All-zero key -> rk0 = rk1 = 0; rk2 = 62636363626363636263636362636363.
- AES_KEXP_STORE_EN defined: after the K stream, keys_ready = 1; rd_idx = 14 gives rd_key = fe4890d1…631e one cycle later; rd_idx = 15 gives rd_key = 0.
